// File: rtl/cpu7_ifu_fetch_seq.sv
// Fetch-request sequencer: owns the fetch PC, issues credit-limited requests,
// tags responses with their PC, drops stale ones and queues them for decode.
module cpu7_ifu_fetch_seq #(
  parameter int GRLEN = 32,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [GRLEN-1:0] pc_init,
  input  logic             redirect_valid,
  input  logic [GRLEN-1:0] redirect_pc,
  output logic             inst_req,
  output logic [GRLEN-1:0] inst_addr,
  output logic             inst_cancel,
  input  logic             inst_addr_ok,
  input  logic             inst_valid,
  input  logic [31:0]      inst_rdata,
  input  logic             inst_ex,
  input  logic [5:0]       inst_exccode,
  output logic             fq_valid,
  output logic [GRLEN-1:0] fq_pc,
  output logic [31:0]      fq_inst,
  output logic             fq_ex,
  output logic [5:0]       fq_exccode,
  input  logic             fq_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {BOOT, RUN, WAITR} state_t;

  state_t           state;
  logic [GRLEN-1:0] pc;
  logic [CW-1:0]    outst, outst_next, discard, fq_count;
  logic [PW-1:0]    fq_rd, fq_wr, tag_rd, tag_wr;

  logic [GRLEN-1:0] tag_pc  [DEPTH];
  logic [GRLEN-1:0] q_pc    [DEPTH];
  logic [31:0]      q_inst  [DEPTH];
  logic             q_ex    [DEPTH];
  logic [5:0]       q_code  [DEPTH];

  logic redir, credit, issue, enq, deq;

  always_comb begin
    redir       = redirect_valid && (state != BOOT);
    // Credit counts queued entries too, so every in-flight response has a slot.
    credit      = ({1'b0, outst} + {1'b0, fq_count}) < (CW+1)'(DEPTH);
    inst_req    = (state == RUN) && !redirect_valid && credit;
    issue       = inst_req && inst_addr_ok;
    inst_cancel = redir && (outst != '0);
    inst_addr   = pc;
    enq         = inst_valid && !redir && (discard == '0) && (state == RUN);
    deq         = fq_valid && fq_ready && !redir;
    outst_next  = outst + CW'(issue) - CW'(inst_valid);
  end

  assign fq_valid   = (fq_count != '0);
  assign fq_pc      = q_pc[fq_rd];
  assign fq_inst    = q_inst[fq_rd];
  assign fq_ex      = q_ex[fq_rd];
  assign fq_exccode = q_code[fq_rd];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= BOOT;
      pc       <= '0;
      outst    <= '0;
      discard  <= '0;
      fq_count <= '0;
      fq_rd    <= '0;
      fq_wr    <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      tag_pc   <= '{default: '0};
      q_pc     <= '{default: '0};
      q_inst   <= '{default: '0};
      q_ex     <= '{default: 1'b0};
      q_code   <= '{default: '0};
    end else begin
      case (state)
        BOOT: begin
          pc    <= pc_init;
          state <= RUN;
        end
        default: begin
          if (redir) begin
            state <= RUN;
            pc    <= redirect_pc;
          end else begin
            if (issue) pc <= pc + GRLEN'(4);
            if (enq && inst_ex) state <= WAITR;
          end
        end
      endcase

      outst <= outst_next;

      // Tag FIFO survives redirects: discarded responses still pop their tag.
      if (issue) begin
        tag_pc[tag_wr] <= pc;
        tag_wr         <= tag_wr + PW'(1);
      end
      if (inst_valid) tag_rd <= tag_rd + PW'(1);

      if (redir) discard <= outst_next;
      else if (inst_valid && (discard != '0)) discard <= discard - CW'(1);

      if (redir) begin
        fq_rd    <= '0;
        fq_wr    <= '0;
        fq_count <= '0;
      end else begin
        if (enq) begin
          q_pc[fq_wr]   <= tag_pc[tag_rd];
          q_inst[fq_wr] <= inst_rdata;
          q_ex[fq_wr]   <= inst_ex;
          q_code[fq_wr] <= inst_exccode;
          fq_wr         <= fq_wr + PW'(1);
        end
        if (deq) fq_rd <= fq_rd + PW'(1);
        fq_count <= fq_count + CW'(enq) - CW'(deq);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (resetn) assert (!(enq && !deq && (fq_count == CW'(DEPTH))));
  end

endmodule

// File: tb/tb_cpu7_ifu_fetch_seq.sv
// Bench for cpu7_ifu_fetch_seq: in-order memory model plus an architectural
// fetch-stream model (sequential PCs from each redirect, stop after an exception).
module tb_cpu7_ifu_fetch_seq;

  localparam int GRLEN = 32;
  localparam int DEPTH = 2;

  logic             clock;
  logic             resetn;
  logic [31:0]      pc_init;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             inst_req;
  logic [31:0]      inst_addr;
  logic             inst_cancel;
  logic             inst_addr_ok;
  logic             inst_valid;
  logic [31:0]      inst_rdata;
  logic             inst_ex;
  logic [5:0]       inst_exccode;
  logic             fq_valid;
  logic [31:0]      fq_pc;
  logic [31:0]      fq_inst;
  logic             fq_ex;
  logic [5:0]       fq_exccode;
  logic             fq_ready;

  cpu7_ifu_fetch_seq #(.GRLEN(GRLEN), .DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn), .pc_init(pc_init),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_valid(inst_valid), .inst_rdata(inst_rdata),
    .inst_ex(inst_ex), .inst_exccode(inst_exccode),
    .fq_valid(fq_valid), .fq_pc(fq_pc), .fq_inst(fq_inst), .fq_ex(fq_ex),
    .fq_exccode(fq_exccode), .fq_ready(fq_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  req_t        pend[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned lat_min  = 1;
  int unsigned lat_max  = 1;
  int          consumed = 0;
  int          acc_cnt  = 0;
  int          c0, a0;
  logic [31:0] exp_issue, exp_pc, last_pc;
  logic        live, boot, last_ex;
  logic [5:0]  last_code;

  function automatic logic [31:0] mem_inst(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic mem_ex(input logic [31:0] a);
    return a[9:2] == 8'h47;
  endfunction

  function automatic logic [5:0] mem_code(input logic [31:0] a);
    return mem_ex(a) ? 6'h08 : a[7:2];
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy, input logic aok);
    logic due;
    redirect_valid = rv;
    redirect_pc    = rpc;
    fq_ready       = rdy;
    inst_addr_ok   = aok;
    due = (pend.size() > 0) && (pend[0].due <= cyc);
    inst_valid = due;
    if (due) begin
      inst_rdata   = mem_inst(pend[0].addr);
      inst_ex      = mem_ex(pend[0].addr);
      inst_exccode = mem_code(pend[0].addr);
    end else begin
      inst_rdata   = '0;
      inst_ex      = 1'b0;
      inst_exccode = '0;
    end
    #1;
    if (boot) chk1("boot_no_req", inst_req, 1'b0);
    chk1("cancel", inst_cancel, rv && (pend.size() != 0));
    if (rv) chk1("req_in_redirect", inst_req, 1'b0);
    if (!live && !rv) chk1("req_after_ex", inst_req, 1'b0);
    if (due) void'(pend.pop_front());
    if (inst_req && aok) begin
      chk32("issue_addr", inst_addr, exp_issue);
      pend.push_back('{addr: inst_addr, due: cyc + $urandom_range(lat_max, lat_min)});
      exp_issue = exp_issue + 32'd4;
      acc_cnt++;
    end
    chk1("inflight_bound", pend.size() <= DEPTH, 1'b1);
    if (rv) begin
      exp_issue = rpc;
      exp_pc    = rpc;
      live      = 1'b1;
    end else if (fq_valid && rdy) begin
      chk1("fq_live", live, 1'b1);
      if (live) begin
        chk32("fq_pc", fq_pc, exp_pc);
        chk32("fq_inst", fq_inst, mem_inst(exp_pc));
        chk1("fq_ex", fq_ex, mem_ex(exp_pc));
        chk32("fq_exccode", 32'(fq_exccode), 32'(mem_code(exp_pc)));
        last_pc   = fq_pc;
        last_ex   = fq_ex;
        last_code = fq_exccode;
        consumed++;
        if (mem_ex(exp_pc)) live = 1'b0;
        else exp_pc = exp_pc + 32'd4;
      end
    end
    boot = 1'b0;
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_reset(input logic [31:0] init);
    resetn         = 1'b0;
    pc_init        = init;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_addr_ok   = 1'b0;
    inst_valid     = 1'b0;
    inst_rdata     = '0;
    inst_ex        = 1'b0;
    inst_exccode   = '0;
    fq_ready       = 1'b0;
    #1;
    chk1("rst_inst_req", inst_req, 1'b0);
    chk1("rst_inst_cancel", inst_cancel, 1'b0);
    chk1("rst_fq_valid", fq_valid, 1'b0);
    chk32("rst_inst_addr", inst_addr, 32'h0);
    chk32("rst_fq_pc", fq_pc, 32'h0);
    chk32("rst_fq_inst", fq_inst, 32'h0);
    chk1("rst_fq_ex", fq_ex, 1'b0);
    chk32("rst_fq_exccode", 32'(fq_exccode), 32'h0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    pend.delete();
    exp_issue = init;
    exp_pc    = init;
    live      = 1'b1;
    boot      = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clock  = 1'b0;
    resetn = 1'b1;
    live   = 1'b1;
    boot   = 1'b0;
    @(negedge clock);

    // Boot and steady fetch with 1-cycle memory.
    do_reset(32'h1C00_0000);
    for (int i = 0; i < 30 && consumed < 3; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    chk1("t1_three_entries", consumed >= 3, 1'b1);

    // Back-pressure: after a redirect, only DEPTH new requests fit.
    cycle(1'b1, 32'h1C00_0040, 1'b0, 1'b1);
    a0 = acc_cnt;
    repeat (10) cycle(1'b0, '0, 1'b0, 1'b1);
    chk32("stall_accepts", 32'(acc_cnt - a0), 32'd2);
    chk1("stall_no_req", inst_req, 1'b0);
    chk1("stall_fq_valid", fq_valid, 1'b1);
    chk1("stall_none_inflight", pend.size() == 0, 1'b1);
    c0 = consumed;
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);
    chk1("stall_drain", consumed - c0 >= 2, 1'b1);
    chk1("stall_resume", acc_cnt - a0 > 2, 1'b1);

    // Redirect with two in flight, then run into the exception at 0x1C00011C.
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 20 && pend.size() != 2; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    chk1("two_inflight", pend.size() == 2, 1'b1);
    cycle(1'b1, 32'h1C00_0100, 1'b1, 1'b1);
    c0 = consumed;
    for (int i = 0; i < 30 && consumed == c0; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    chk32("first_after_redirect", last_pc, 32'h1C00_0100);
    for (int i = 0; i < 100 && live; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    chk1("ex_reached", live, 1'b0);
    chk1("ex_flag", last_ex, 1'b1);
    chk32("ex_code", 32'(last_code), 32'h08);
    repeat (8) cycle(1'b0, '0, 1'b1, 1'b1);
    chk1("ex_no_younger", fq_valid, 1'b0);

    // Redirect coinciding with the only in-flight response.
    lat_min = 1; lat_max = 1;
    cycle(1'b1, 32'h1C00_0200, 1'b1, 1'b1);
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !(pend.size() == 1 && pend[0].due <= cyc); i++)
      cycle(1'b0, '0, 1'b1, 1'b1);
    chk1("one_due", pend.size() == 1 && pend[0].due <= cyc, 1'b1);
    cycle(1'b1, 32'h1C00_0300, 1'b1, 1'b1);
    c0 = consumed;
    for (int i = 0; i < 30 && consumed == c0; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    chk32("no_stale_after_redirect", last_pc, 32'h1C00_0300);

    // PC wraps past the top of the address space.
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    c0 = consumed;
    for (int i = 0; i < 40 && consumed - c0 < 3; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    chk32("wrap_pc", last_pc, 32'h0000_0000);

    // Reset while two requests are in flight.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && pend.size() != 2; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    chk1("two_inflight_rst", pend.size() == 2, 1'b1);
    do_reset(32'h1C00_0400);
    c0 = consumed;
    for (int i = 0; i < 40 && consumed - c0 < 2; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    chk1("rst_resume", consumed - c0 >= 2, 1'b1);

    // Randomized traffic: latency, acceptance, back-pressure and redirects.
    lat_min = 1; lat_max = 3;
    c0 = consumed;
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(24, 0) == 0,
            32'h1C00_0000 + ($urandom_range(255, 0) << 2),
            $urandom_range(9, 0) < 7,
            $urandom_range(3, 0) != 0);
    chk1("random_progress", consumed - c0 > 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
